// File: rtl/ieee_adder_sched.sv
// ieee_adder_sched: two-port round-robin scheduler in front of a shared,
// three-stage IEEE-754 single-precision adder (truncating, no NaN/Inf handling).
// Each port has credit control and its own in-order response FIFO.
// Optional statistics counters are enabled by defining IEEE_SCHED_STATS_EN.
`ifndef WIDTH_NUMBER
`define WIDTH_NUMBER 32
`endif

module ieee_adder_sched #(
   parameter int PIPE_DEPTH = 3,
   parameter int OUT_DEPTH  = 2
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     a_valid,
   output logic                     a_ready,
   input  logic [`WIDTH_NUMBER-1:0] a_opx,
   input  logic [`WIDTH_NUMBER-1:0] a_opy,
   input  logic                     a_sub,
   output logic                     a_rsp_valid,
   input  logic                     a_rsp_ready,
   output logic [`WIDTH_NUMBER-1:0] a_rsp_data,
   input  logic                     b_valid,
   output logic                     b_ready,
   input  logic [`WIDTH_NUMBER-1:0] b_opx,
   input  logic [`WIDTH_NUMBER-1:0] b_opy,
   input  logic                     b_sub,
   output logic                     b_rsp_valid,
   input  logic                     b_rsp_ready,
   output logic [`WIDTH_NUMBER-1:0] b_rsp_data,
   output logic                     busy
`ifdef IEEE_SCHED_STATS_EN
   ,
   output logic [31:0]              stat_grant_a,
   output logic [31:0]              stat_grant_b,
   output logic [31:0]              stat_stall
`endif
);

   localparam int CW = $clog2(OUT_DEPTH + 1);
   localparam int PW = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;
   localparam int W  = `WIDTH_NUMBER;

   logic [1:0]        elig;
   logic [1:0]        grant;
   logic [1:0]        rspReady;
   logic [1:0]        rspValid;
   logic [1:0][W-1:0] rspData;
   logic              lastGrantReg;   // 0 = A, 1 = B

   // Stage registers
   logic              s1Valid, s1Tag;
   logic [W-1:0]      s1X, s1Y;
   logic              s2Valid, s2Tag, s2Sign, s2EffSub;
   logic [7:0]        s2Exp, s2Diff;
   logic [23:0]       s2BigSig, s2SmallSig;
   logic              s3Valid, s3Tag;
   logic [W-1:0]      s3Sum;
   logic [PIPE_DEPTH-1:0] pipeValid;

   // Stage combinational signals
   logic              xBig;
   logic [W-1:0]      bigOp, smallOp;
   logic [23:0]       alignedSig;
   logic [24:0]       rawSum;
   logic [4:0]        msb, lzc;
   logic [22:0]       normSig;
   logic [W-1:0]      sumNext;

   assign rspReady = {b_rsp_ready, a_rsp_ready};

   // Round-robin: on a conflict the port not granted last time wins; ready is
   // forced low while reset is asserted.
   assign a_ready = rst_n & elig[0] & (~(b_valid & elig[1]) | lastGrantReg);
   assign b_ready = rst_n & elig[1] & (~(a_valid & elig[0]) | ~lastGrantReg);
   assign grant   = {b_valid & b_ready, a_valid & a_ready};

   // Remember the last port that actually handshook.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)        lastGrantReg <= 1'b1;
      else if (grant[0]) lastGrantReg <= 1'b0;
      else if (grant[1]) lastGrantReg <= 1'b1;
   end

   // S1: capture the granted operands; subtraction is folded into Y's sign.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1Valid <= 1'b0;
         s1Tag   <= 1'b0;
         s1X     <= '0;
         s1Y     <= '0;
      end else begin
         s1Valid <= |grant;
         if (|grant) begin
            s1Tag <= grant[1];
            s1X   <= grant[1] ? b_opx : a_opx;
            s1Y   <= (grant[1] ? b_opy : a_opy) ^ {(grant[1] ? b_sub : a_sub), {(W-1){1'b0}}};
         end
      end
   end

   // Magnitude compare picks the larger operand, so the subtract below never underflows.
   always_comb begin
      xBig    = s1X[30:0] >= s1Y[30:0];
      bigOp   = xBig ? s1X : s1Y;
      smallOp = xBig ? s1Y : s1X;
   end

   // S2: prepared sign/exponent/significands and exponent difference.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s2Valid    <= 1'b0;
         s2Tag      <= 1'b0;
         s2Sign     <= 1'b0;
         s2EffSub   <= 1'b0;
         s2Exp      <= '0;
         s2Diff     <= '0;
         s2BigSig   <= '0;
         s2SmallSig <= '0;
      end else begin
         s2Valid    <= s1Valid;
         s2Tag      <= s1Tag;
         s2Sign     <= bigOp[31];
         s2EffSub   <= s1X[31] ^ s1Y[31];
         s2Exp      <= bigOp[30:23];
         s2Diff     <= bigOp[30:23] - smallOp[30:23];
         s2BigSig   <= {|bigOp[30:23], bigOp[22:0]};
         s2SmallSig <= {|smallOp[30:23], smallOp[22:0]};
      end
   end

   // Align, add/subtract and normalise; bits shifted out are simply dropped.
   always_comb begin
      alignedSig = s2SmallSig >> s2Diff;
      rawSum     = s2EffSub ? ({1'b0, s2BigSig} - {1'b0, alignedSig})
                            : ({1'b0, s2BigSig} + {1'b0, alignedSig});
      msb = '0;
      for (int i = 0; i < 24; i++) begin
         if (rawSum[i]) msb = 5'(i);
      end
      lzc     = 5'd23 - msb;
      normSig = rawSum[22:0] << lzc;
      sumNext = '0;
      if (rawSum[24])
         sumNext = {s2Sign, s2Exp + 8'd1, rawSum[23:1]};
      else if (rawSum[23:0] != 24'd0)
         sumNext = {s2Sign, s2Exp - {3'b000, lzc}, normSig};
   end

   // S3: register the finished sum; it is written to its port's FIFO next edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s3Valid <= 1'b0;
         s3Tag   <= 1'b0;
         s3Sum   <= '0;
      end else begin
         s3Valid <= s2Valid;
         s3Tag   <= s2Tag;
         s3Sum   <= sumNext;
      end
   end

   assign pipeValid = {s3Valid, s2Valid, s1Valid};

   for (genvar gi = 0; gi < 2; gi++) begin : gPort
      logic [CW-1:0] cntReg, occReg;
      logic [PW-1:0] wrPtrReg, rdPtrReg;
      logic [W-1:0]  mem [OUT_DEPTH];
      logic          retire, pop;

      assign retire       = s3Valid && (s3Tag == 1'(gi));
      assign pop          = (occReg != '0) && rspReady[gi];
      assign elig[gi]     = cntReg < CW'(OUT_DEPTH);
      assign rspValid[gi] = occReg != '0;
      assign rspData[gi]  = rspValid[gi] ? mem[rdPtrReg] : '0;

      // Credits: in-flight plus buffered; a retire only moves an op between the two.
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) cntReg <= '0;
         else        cntReg <= cntReg + CW'(grant[gi]) - CW'(pop);
      end

      // FIFO occupancy and pointers.
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            occReg   <= '0;
            wrPtrReg <= '0;
            rdPtrReg <= '0;
         end else begin
            occReg <= occReg + CW'(retire) - CW'(pop);
            if (retire) wrPtrReg <= (wrPtrReg == PW'(OUT_DEPTH - 1)) ? '0 : wrPtrReg + 1'b1;
            if (pop)    rdPtrReg <= (rdPtrReg == PW'(OUT_DEPTH - 1)) ? '0 : rdPtrReg + 1'b1;
         end
      end

      // FIFO storage; stale contents are masked by the occupancy count.
      always_ff @(posedge clk) begin
         if (retire) mem[wrPtrReg] <= s3Sum;
      end
   end

   assign a_rsp_valid = rspValid[0];
   assign b_rsp_valid = rspValid[1];
   assign a_rsp_data  = rspData[0];
   assign b_rsp_data  = rspData[1];
   assign busy        = (|pipeValid) | (|rspValid);

`ifdef IEEE_SCHED_STATS_EN
   // Grant counts per port and cycles where a request waited without a handshake.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stat_grant_a <= '0;
         stat_grant_b <= '0;
         stat_stall   <= '0;
      end else begin
         if (grant[0]) stat_grant_a <= stat_grant_a + 32'd1;
         if (grant[1]) stat_grant_b <= stat_grant_b + 32'd1;
         if ((a_valid | b_valid) && !(|grant)) stat_stall <= stat_stall + 32'd1;
      end
   end
`endif

endmodule
